// File: rtl/flash_pkg.sv
// Shared definitions for the SPI NOR flash sequencers: opcodes, status bits,
// and the state encodings used by the erase sequencer and its handshake helper.
package flash_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_CE   = 8'hC7;
    localparam logic [7:0] CMD_SE   = 8'h20;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam int WIP = 0;

    typedef enum logic [3:0] {
        IDLE,
        WREN_GO,
        WREN_WAIT,
        GAP1,
        ERASE_GO,
        ERASE_WAIT,
        POLL_DLY,
        POLL_GO,
        POLL_WAIT,
        CHECK,
        FINISH,
        FAIL
    } state_e;

    typedef enum logic [1:0] {
        TW_IDLE,
        TW_TRIG2,
        TW_RISE,
        TW_FALL
    } txn_state_e;

    // Right-aligned 4 KB sector erase frame: opcode, sector address, zero offset.
    function automatic logic [127:0] sector_erase_frame(input logic [11:0] sector_hi);
        return {96'b0, CMD_SE, sector_hi, 12'h000};
    endfunction

endpackage

// File: rtl/spi_txn_wait.sv
// One spictl transaction: a two-cycle trig pulse, then wait for isbusy to rise
// (bounded by HS_TIMEOUT) and fall again (unbounded).
module spi_txn_wait
    import flash_pkg::*;
#(
    parameter int HS_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic isbusy,
    output logic trig,
    output logic txn_done,
    output logic txn_fail
);

    txn_state_e  st_q, st_d;
    logic [31:0] cnt_q, cnt_d;
    logic        trig_q, trig_d;
    logic        txn_done_q, txn_done_d;
    logic        txn_fail_q, txn_fail_d;

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        trig_d     = 1'b0;
        txn_done_d = 1'b0;
        txn_fail_d = 1'b0;
        case (st_q)
            TW_IDLE: begin
                if (go) begin
                    trig_d = 1'b1;
                    st_d   = TW_TRIG2;
                end
            end
            // isbusy seen during the second trig cycle already counts as risen
            TW_TRIG2: begin
                trig_d = 1'b1;
                cnt_d  = '0;
                st_d   = isbusy ? TW_FALL : TW_RISE;
            end
            TW_RISE: begin
                if (isbusy) begin
                    st_d = TW_FALL;
                end else if (cnt_q == 32'(HS_TIMEOUT)) begin
                    txn_fail_d = 1'b1;
                    st_d       = TW_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            TW_FALL: begin
                if (!isbusy) begin
                    txn_done_d = 1'b1;
                    st_d       = TW_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= TW_IDLE;
            cnt_q      <= '0;
            trig_q     <= 1'b0;
            txn_done_q <= 1'b0;
            txn_fail_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            trig_q     <= trig_d;
            txn_done_q <= txn_done_d;
            txn_fail_q <= txn_fail_d;
        end
    end

    assign trig     = trig_q;
    assign txn_done = txn_done_q;
    assign txn_fail = txn_fail_q;

endmodule

// File: rtl/flash_erase_seq.sv
// SPI NOR erase sequencer: WREN, chip or sector erase, then status polling
// until WIP clears or the poll budget runs out, behind a start/done handshake.
module flash_erase_seq
    import flash_pkg::*;
#(
    parameter int GAP_CYCLES    = 16,
    parameter int POLL_INTERVAL = 50000,
    parameter int POLL_MAX      = 4000,
    parameter int HS_TIMEOUT    = 1024
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         start,
    input  logic         sector,
    input  logic [23:0]  addr,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [7:0]   status,
    output logic         trig,
    output logic [7:0]   datalength,
    output logic [127:0] senddata,
    input  logic         isbusy,
    input  logic [127:0] recvdata
);

    localparam int PCNT_W = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);

    state_e              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d, pcnt_inc;
    logic                sector_q, sector_d;
    logic [11:0]         sect_hi_q, sect_hi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [7:0]          status_q, status_d;
    logic [7:0]          dlen_q, dlen_d;
    logic [127:0]        sdata_q, sdata_d;
    logic                fail_now;
    logic                txn_go, txn_done, txn_fail;
    logic                unused_bits;

    assign txn_go   = (state_q == WREN_GO) || (state_q == ERASE_GO) || (state_q == POLL_GO);
    assign pcnt_inc = pcnt_q + 1'b1;

    spi_txn_wait #(
        .HS_TIMEOUT(HS_TIMEOUT)
    ) u_txn (
        .clk      (sclk),
        .rst      (rst),
        .go       (txn_go),
        .isbusy   (isbusy),
        .trig     (trig),
        .txn_done (txn_done),
        .txn_fail (txn_fail)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        sector_d  = sector_q;
        sect_hi_d = sect_hi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        status_d  = status_q;
        dlen_d    = dlen_q;
        sdata_d   = sdata_q;
        fail_now  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sector_d  = sector;
                    sect_hi_d = addr[23:12];
                    pcnt_d    = '0;
                    cnt_d     = '0;
                    state_d   = WREN_GO;
                end
            end
            WREN_GO: begin
                busy_d  = 1'b1;
                dlen_d  = 8'd8;
                sdata_d = {120'b0, CMD_WREN};
                state_d = WREN_WAIT;
            end
            WREN_WAIT: begin
                if (txn_fail) begin
                    fail_now = 1'b1;
                end else if (txn_done) begin
                    cnt_d   = '0;
                    state_d = GAP1;
                end
            end
            GAP1: begin
                if (cnt_q + 32'd1 >= 32'(GAP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ERASE_GO;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ERASE_GO: begin
                if (sector_q) begin
                    dlen_d  = 8'd32;
                    sdata_d = sector_erase_frame(sect_hi_q);
                end else begin
                    dlen_d  = 8'd8;
                    sdata_d = {120'b0, CMD_CE};
                end
                state_d = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                if (txn_fail) begin
                    fail_now = 1'b1;
                end else if (txn_done) begin
                    cnt_d   = '0;
                    state_d = POLL_DLY;
                end
            end
            POLL_DLY: begin
                if (cnt_q + 32'd1 >= 32'(POLL_INTERVAL)) begin
                    cnt_d   = '0;
                    state_d = POLL_GO;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            POLL_GO: begin
                dlen_d  = 8'd16;
                sdata_d = {112'b0, CMD_RDSR, 8'h00};
                state_d = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (txn_fail) begin
                    fail_now = 1'b1;
                end else if (txn_done) begin
                    state_d = CHECK;
                end
            end
            // done/error are registered on entry so they coincide with FINISH/FAIL
            CHECK: begin
                status_d = recvdata[7:0];
                pcnt_d   = pcnt_inc;
                if (!recvdata[WIP]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else if (pcnt_inc == PCNT_W'(POLL_MAX)) begin
                    fail_now = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = POLL_DLY;
                end
            end
            FINISH:  state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fail_now) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = FAIL;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            status_q <= 8'h00;
            dlen_q   <= 8'h00;
            sdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            sector_q  <= sector_d;
            sect_hi_q <= sect_hi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            status_q  <= status_d;
            dlen_q    <= dlen_d;
            sdata_q   <= sdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign status     = status_q;
    assign datalength = dlen_q;
    assign senddata   = sdata_q;

    assign unused_bits = ^{addr[11:0], recvdata[127:8]};

endmodule

// File: tb/tb_flash_erase_seq.sv
// Bench for flash_erase_seq: a behavioural spictl model answers transactions and
// every erase is compared against a transaction list derived from the erase rules.
module tb_flash_erase_seq;

    localparam int GAP = 4;
    localparam int PI  = 10;
    localparam int PM  = 4;
    localparam int HS  = 20;

    logic         sclk = 1'b0;
    logic         rst, start, sector, isbusy;
    logic [23:0]  addr;
    logic         busy, done, error, trig;
    logic [7:0]   status, datalength;
    logic [127:0] senddata, recvdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]   resp_q[$];
    logic [7:0]   plan_q[$];
    int           txn_dl_q[$];
    logic [127:0] txn_sd_q[$];
    int           txn_cyc_q[$];
    int           gap_q[$];
    bit           hs_drop = 1'b0;
    int           done_tot = 0, err_tot = 0, err_cyc = 0;
    logic [7:0]   exp_status = 8'h00;

    flash_erase_seq #(
        .GAP_CYCLES(GAP), .POLL_INTERVAL(PI), .POLL_MAX(PM), .HS_TIMEOUT(HS)
    ) dut (
        .sclk(sclk), .rst(rst), .start(start), .sector(sector), .addr(addr),
        .busy(busy), .done(done), .error(error), .status(status), .trig(trig),
        .datalength(datalength), .senddata(senddata), .isbusy(isbusy), .recvdata(recvdata)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        if (done) done_tot <= done_tot + 1;
        if (error) begin
            err_tot <= err_tot + 1;
            err_cyc <= cyc;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // spictl stand-in: one transfer per trig rising edge, random latency and length
    initial begin : spictl_model
        bit tprev;
        int lat, dur, last_fall;
        logic [7:0] b;
        isbusy = 1'b0;
        recvdata = '0;
        tprev = 1'b0;
        last_fall = 0;
        forever begin
            @(negedge sclk);
            if (trig && !tprev) begin
                txn_dl_q.push_back(int'(datalength));
                txn_sd_q.push_back(senddata);
                txn_cyc_q.push_back(cyc);
                gap_q.push_back(cyc - last_fall);
                if (!hs_drop) begin
                    lat = $urandom_range(0, 3);
                    repeat (lat) @(negedge sclk);
                    isbusy = 1'b1;
                    dur = $urandom_range(2, 6);
                    repeat (dur) @(negedge sclk);
                    if (datalength == 8'd16 && senddata[15:8] == 8'h05) begin
                        if (resp_q.size() > 0) b = resp_q.pop_front();
                        else b = 8'h00;
                        recvdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                        recvdata[7:0] = b;
                    end
                    isbusy = 1'b0;
                    last_fall = cyc;
                end
            end
            tprev = trig;
        end
    end

    task automatic pulse_start(input bit sec, input logic [23:0] a);
        @(negedge sclk);
        start = 1'b1;
        sector = sec;
        addr = a;
        @(negedge sclk);
        start = 1'b0;
        sector = $urandom_range(0, 1);
        addr = 24'($urandom);
    endtask

    // Runs one erase whose status responses are in plan_q and checks it end to end.
    task automatic do_erase(input bit sec, input logic [23:0] a, input bit hsd, input bit inj);
        int base, d0, e0, n, injected, ok_gaps;
        bit seen;
        int exp_dl[$];
        logic [127:0] exp_sd[$];
        int exp_done, exp_err;
        exp_done = 0;
        exp_err = 0;
        exp_dl.push_back(8);
        exp_sd.push_back(128'h06);
        if (hsd) begin
            exp_err = 1;
        end else begin
            exp_dl.push_back(sec ? 32 : 8);
            exp_sd.push_back(sec ? {96'b0, 8'h20, a[23:12], 12'h000} : 128'hC7);
            for (int i = 0; i < plan_q.size(); i++) begin
                exp_dl.push_back(16);
                exp_sd.push_back(128'h0500);
                exp_status = plan_q[i];
                if (plan_q[i][0] == 1'b0) begin exp_done = 1; break; end
                if (i + 1 == PM) begin exp_err = 1; break; end
            end
        end
        resp_q.delete();
        foreach (plan_q[i]) resp_q.push_back(plan_q[i]);
        hs_drop = hsd;
        base = txn_dl_q.size();
        d0 = done_tot;
        e0 = err_tot;

        @(negedge sclk);
        start = 1'b1;
        sector = sec;
        addr = a;
        @(negedge sclk);
        start = 1'b0;
        check_val("trig_pre", trig, 1'b0);
        @(negedge sclk);
        check_val("trig_first", trig, 1'b1);
        check_val("busy_first", busy, 1'b1);
        check_val("dl_wren", datalength, 8'd8);
        check_val("sd_wren", senddata, 128'h06);
        @(negedge sclk);
        check_val("trig_second", trig, 1'b1);
        @(negedge sclk);
        check_val("trig_drop", trig, 1'b0);

        seen = 1'b0;
        injected = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge sclk);
            if (injected == 1) begin start = 1'b0; injected = 2; end
            if (inj && injected == 0 && (txn_dl_q.size() - base) == 2 && isbusy) begin
                start = 1'b1;
                sector = ~sec;
                injected = 1;
            end
            if (done || error) begin
                seen = 1'b1;
                check_val("busy_at_end", busy, 1'b0);
            end
        end
        start = 1'b0;
        check_val("end_seen", seen, 1'b1);
        if (inj) check_val("start_injected", injected != 0, 1'b1);
        repeat (40) @(negedge sclk);

        n = txn_dl_q.size() - base;
        check_val("txn_count", n, exp_dl.size());
        for (int j = 0; j < n && j < exp_dl.size(); j++) begin
            check_val($sformatf("txn%0d_dl", j), txn_dl_q[base + j], exp_dl[j]);
            check_val($sformatf("txn%0d_sd", j), txn_sd_q[base + j], exp_sd[j]);
        end
        check_val("done_pulses", done_tot - d0, exp_done);
        check_val("error_pulses", err_tot - e0, exp_err);
        check_val("status", status, exp_status);
        check_val("busy_idle", busy, 1'b0);
        if (hsd && n > 0) check_val("hs_latency", err_cyc - txn_cyc_q[base], HS + 3);
        if (!hsd) begin
            ok_gaps = 1;
            for (int j = 1; j < n; j++)
                if (gap_q[base + j] < ((j == 1) ? GAP + 1 : PI + 1)) ok_gaps = 0;
            check_val("min_gaps", ok_gaps, 1);
        end
        hs_drop = 1'b0;
    endtask

    task automatic reset_mid_erase();
        int base, d0, e0, ntx;
        bit ok;
        resp_q.delete();
        repeat (6) resp_q.push_back(8'h01);
        hs_drop = 1'b0;
        base = txn_dl_q.size();
        pulse_start(1'b0, 24'h000000);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge sclk);
            if ((txn_dl_q.size() - base) >= 2 && isbusy) ok = 1'b1;
        end
        for (int k = 0; k < 2000 && ok && isbusy; k++) @(negedge sclk);
        check_val("rm_reached_erase", ok && !isbusy, 1'b1);
        repeat (3) @(negedge sclk);
        d0 = done_tot;
        e0 = err_tot;
        ntx = txn_dl_q.size();
        rst = 1'b1;
        @(negedge sclk);
        check_val("rm_trig", trig, 1'b0);
        check_val("rm_busy", busy, 1'b0);
        check_val("rm_done", done, 1'b0);
        check_val("rm_error", error, 1'b0);
        check_val("rm_status", status, 8'h00);
        check_val("rm_dl", datalength, 8'h00);
        check_val("rm_sd", senddata, 128'h0);
        rst = 1'b0;
        exp_status = 8'h00;
        repeat (30) @(negedge sclk);
        check_val("rm_no_pulse", (done_tot - d0) + (err_tot - e0), 0);
        check_val("rm_no_txn", txn_dl_q.size() - ntx, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sector = 1'b0;
        addr = 24'h0;
        repeat (3) @(negedge sclk);
        check_val("rst_trig", trig, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_error", error, 1'b0);
        check_val("rst_status", status, 8'h00);
        check_val("rst_dl", datalength, 8'h00);
        check_val("rst_sd", senddata, 128'h0);
        rst = 1'b0;
        repeat (2) @(negedge sclk);

        plan_q = '{8'h03, 8'h03, 8'h03, 8'h00};
        do_erase(1'b0, 24'h5A5A5A, 1'b0, 1'b0);

        plan_q = '{8'h00};
        do_erase(1'b1, 24'h123ABC, 1'b0, 1'b0);

        plan_q = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
        do_erase(1'b1, 24'hFFFFFF, 1'b0, 1'b0);

        reset_mid_erase();

        plan_q = '{8'h03, 8'h03, 8'h03, 8'h00};
        do_erase(1'b0, 24'h000000, 1'b0, 1'b0);

        plan_q.delete();
        do_erase(1'b0, 24'h000000, 1'b1, 1'b0);

        plan_q = '{8'h01, 8'h00};
        do_erase(1'b1, 24'h0ABCDE, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int nb;
            nb = $urandom_range(0, PM);
            plan_q.delete();
            for (int i = 0; i < nb; i++) plan_q.push_back(8'($urandom) | 8'h01);
            plan_q.push_back(8'($urandom) & 8'hFE);
            do_erase(1'($urandom), 24'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
